// File: rtl/vector_cache_pkg.sv
// Shared vector-cache types used by the RDB response egress path.
package vector_cache_pkg;

  localparam int unsigned DB_ENTRY_IDX_WIDTH   = 6;
  localparam int unsigned MSHR_ENTRY_IDX_WIDTH = 5;
  localparam int unsigned TXNID_WIDTH          = 8;

  localparam int unsigned RSP_LINE_WIDTH      = 1024;
  localparam int unsigned RSP_BEAT_WIDTH      = 256;
  localparam int unsigned RSP_BEATS           = RSP_LINE_WIDTH / RSP_BEAT_WIDTH;
  localparam int unsigned RSP_BEAT_IDX_WIDTH  = (RSP_BEATS > 1) ? $clog2(RSP_BEATS) : 1;
  localparam int unsigned RDB_RD_LAT_DEFAULT  = 2;

  typedef struct packed {
    logic [DB_ENTRY_IDX_WIDTH-1:0]   db_entry_id;
    logic [TXNID_WIDTH-1:0]          txnid;
    logic [MSHR_ENTRY_IDX_WIDTH-1:0] rob_entry_id;
  } read_rdb_addr_t;

  typedef struct packed {
    logic [RSP_BEAT_WIDTH-1:0]     data;
    logic [TXNID_WIDTH-1:0]        txnid;
    logic [RSP_BEAT_IDX_WIDTH-1:0] beat_idx;
    logic                          last;
  } rsp_beat_t;

endpackage

// File: rtl/rdb_rsp_egress_if.sv
// Upstream response channel: beat-level valid/ready handshake.
interface rdb_rsp_egress_if;
  import vector_cache_pkg::*;

  logic      us_rsp_vld;
  rsp_beat_t us_rsp_pld;
  logic      us_rsp_rdy;

  modport master (output us_rsp_vld, output us_rsp_pld, input us_rsp_rdy);
  modport slave  (input us_rsp_vld, input us_rsp_pld, output us_rsp_rdy);
endinterface

// File: rtl/rdb_rsp_egress_sync_fifo.sv
// Generic synchronous FIFO with a registered first-word-fall-through head.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers, occupancy and the registered head word.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
      // Head register tracks mem[rd_ptr]; a push into an (effectively) empty
      // FIFO bypasses the array so the word is visible the very next cycle.
      if (do_pop && count > (AW+1)'(1))
        dout <= mem[rd_ptr + 1'b1];
      else if (do_push && (count == '0 || (do_pop && count == (AW+1)'(1))))
        dout <= din;
    end
  end

endmodule

// File: rtl/rdb_rsp_egress.sv
// RDB response egress: capture RDB read lines after a fixed latency, buffer
// them, and serialize each line into beats on the upstream response channel.
module rdb_rsp_egress
  import vector_cache_pkg::*;
#(
  parameter int unsigned LINE_WIDTH = RSP_LINE_WIDTH,
  parameter int unsigned BEAT_WIDTH = RSP_BEAT_WIDTH,
  parameter int unsigned RDB_RD_LAT = RDB_RD_LAT_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rdb_rd_issue_vld,
  input  read_rdb_addr_t                  rdb_rd_issue_pld,
  output logic                            rdb_rd_issue_rdy,
  input  logic [LINE_WIDTH-1:0]           rdb_rd_data,
  rdb_rsp_egress_if.master                us,
  output logic                            rdb_free_vld,
  output logic [DB_ENTRY_IDX_WIDTH-1:0]   rdb_free_idx,
  output logic                            rsp_done,
  output logic [MSHR_ENTRY_IDX_WIDTH-1:0] rsp_done_idx
);

  localparam int unsigned BEATS   = LINE_WIDTH / BEAT_WIDTH;
  localparam int unsigned CRED_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned ENTRY_W = LINE_WIDTH + TXNID_WIDTH + MSHR_ENTRY_IDX_WIDTH;
  localparam logic [CRED_W-1:0]             CRED_MAX  = CRED_W'(FIFO_DEPTH);
  localparam logic [RSP_BEAT_IDX_WIDTH-1:0] LAST_BEAT = RSP_BEAT_IDX_WIDTH'(BEATS - 1);

  typedef enum logic {IDLE, SEND} ser_state_e;

  logic [CRED_W-1:0]             cred;
  logic                          launch;
  logic                          pipe_vld [RDB_RD_LAT];
  read_rdb_addr_t                pipe_pld [RDB_RD_LAT];
  logic                          push;
  logic                          pop;
  logic [ENTRY_W-1:0]            fifo_din;
  logic [ENTRY_W-1:0]            fifo_dout;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic [CRED_W-1:0]             fifo_count;
  logic [LINE_WIDTH-1:0]         head_data;
  logic [TXNID_WIDTH-1:0]        head_txnid;
  logic [MSHR_ENTRY_IDX_WIDTH-1:0] head_rob;
  ser_state_e                    state;
  logic [RSP_BEAT_IDX_WIDTH-1:0] bcnt;
  logic                          hs;
  logic                          last_hs;
  rsp_beat_t                     beat;

  assign rdb_rd_issue_rdy = (cred != '0) && !rst;
  assign launch           = rdb_rd_issue_vld && rdb_rd_issue_rdy;

  // Credits cover lines in the launch pipe plus lines held in the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      cred <= CRED_MAX;
    end else if (launch && !pop) begin
      cred <= cred - 1'b1;
    end else if (pop && !launch) begin
      cred <= cred + 1'b1;
    end
  end

  // Launch pipe: delays the read descriptor to line up with rdb_rd_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < RDB_RD_LAT; i++) begin
        pipe_vld[i] <= 1'b0;
        pipe_pld[i] <= '0;
      end
    end else begin
      pipe_vld[0] <= launch;
      pipe_pld[0] <= launch ? rdb_rd_issue_pld : '0;
      for (int unsigned i = 1; i < RDB_RD_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_pld[i] <= pipe_pld[i-1];
      end
    end
  end

  assign push         = pipe_vld[RDB_RD_LAT-1];
  assign rdb_free_vld = push && !rst;
  assign rdb_free_idx = pipe_pld[RDB_RD_LAT-1].db_entry_id;
  assign fifo_din     = {rdb_rd_data, pipe_pld[RDB_RD_LAT-1].txnid,
                         pipe_pld[RDB_RD_LAT-1].rob_entry_id};

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign {head_data, head_txnid, head_rob} = fifo_dout;

  assign hs      = (state == SEND) && us.us_rsp_rdy;
  assign last_hs = hs && (bcnt == LAST_BEAT);
  assign pop     = last_hs;

  // Serializer FSM: SEND exactly while a head line exists; a push entering an
  // empty FIFO moves to SEND on the same edge so the first beat is not delayed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      bcnt         <= '0;
      rsp_done     <= 1'b0;
      rsp_done_idx <= '0;
    end else begin
      rsp_done <= last_hs;
      if (last_hs) rsp_done_idx <= head_rob;
      case (state)
        IDLE: begin
          if (push) state <= SEND;
        end
        SEND: begin
          if (last_hs) begin
            bcnt  <= '0;
            state <= (fifo_count > CRED_W'(1) || push) ? SEND : IDLE;
          end else if (hs) begin
            bcnt <= bcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Beat view of the head line selected by the beat counter.
  always_comb begin
    beat          = '0;
    beat.data     = head_data[bcnt*BEAT_WIDTH +: BEAT_WIDTH];
    beat.txnid    = head_txnid;
    beat.beat_idx = bcnt;
    beat.last     = (bcnt == LAST_BEAT);
  end

  assign us.us_rsp_vld = (state == SEND);
  assign us.us_rsp_pld = beat;

  a_cred_max: assert property (@(posedge clk) disable iff (rst) cred <= CRED_MAX);
  a_cred_no_overflow: assert property (@(posedge clk) disable iff (rst)
    (pop && !launch) |-> (cred != CRED_MAX));
  a_cred_no_underflow: assert property (@(posedge clk) disable iff (rst)
    launch |-> (cred != '0));
  a_push_not_full: assert property (@(posedge clk) disable iff (rst) push |-> !fifo_full);
  a_send_has_head: assert property (@(posedge clk) disable iff (rst)
    (state == SEND) |-> !fifo_empty);

endmodule

// File: tb/tb_rdb_rsp_egress.sv
// Bench for rdb_rsp_egress: directed scenarios plus random traffic against a
// transaction-level model (launch order queue, outstanding-line count).
module tb_rdb_rsp_egress;
  import vector_cache_pkg::*;

  localparam int unsigned LW    = 1024;
  localparam int unsigned BW    = 256;
  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned BEATS = LW / BW;
  localparam int unsigned CW    = 512;

  logic                            clk = 1'b0;
  logic                            rst;
  logic                            issue_vld;
  read_rdb_addr_t                  issue_pld;
  logic                            issue_rdy;
  logic [LW-1:0]                   rd_data;
  logic                            free_vld;
  logic [DB_ENTRY_IDX_WIDTH-1:0]   free_idx;
  logic                            done;
  logic [MSHR_ENTRY_IDX_WIDTH-1:0] done_idx;

  rdb_rsp_egress_if us_if ();

  rdb_rsp_egress #(
    .LINE_WIDTH (LW),
    .BEAT_WIDTH (BW),
    .RDB_RD_LAT (LAT),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .rdb_rd_issue_vld (issue_vld),
    .rdb_rd_issue_pld (issue_pld),
    .rdb_rd_issue_rdy (issue_rdy),
    .rdb_rd_data      (rd_data),
    .us               (us_if),
    .rdb_free_vld     (free_vld),
    .rdb_free_idx     (free_idx),
    .rsp_done         (done),
    .rsp_done_idx     (done_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                              cap;
    logic [TXNID_WIDTH-1:0]          txn;
    logic [MSHR_ENTRY_IDX_WIDTH-1:0] rob;
  } line_t;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int outstanding = 0;
  int bidx = 0;
  int n_acc = 0;
  logic post_rst = 1'b0;
  line_t q[$];
  logic [LW-1:0]                   data_at [int];
  logic [DB_ENTRY_IDX_WIDTH-1:0]   free_at [int];
  logic [MSHR_ENTRY_IDX_WIDTH-1:0] done_at [int];

  task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic read_rdb_addr_t mk(input int unsigned db, input int unsigned txn,
                                        input int unsigned rob);
    read_rdb_addr_t p;
    p.db_entry_id  = DB_ENTRY_IDX_WIDTH'(db);
    p.txnid        = TXNID_WIDTH'(txn);
    p.rob_entry_id = MSHR_ENTRY_IDX_WIDTH'(rob);
    return p;
  endfunction

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
  task automatic cycle(input logic v, input read_rdb_addr_t p, input logic ur, input logic r);
    logic          exp_rdy;
    logic          exp_vld;
    logic          exp_free;
    logic          exp_done;
    logic [LW-1:0] line;
    rsp_beat_t     eb;
    @(posedge clk);
    #1;
    rst       = r;
    issue_vld = v;
    issue_pld = p;
    us_if.us_rsp_rdy = ur;
    for (int unsigned i = 0; i < LW / 32; i++) line[i*32 +: 32] = $urandom;
    rd_data      = line;
    data_at[cyc] = line;
    #3;
    exp_rdy = !r && (outstanding < int'(DEPTH));
    check("issue_rdy", CW'(issue_rdy), CW'(exp_rdy));
    if (v && issue_rdy) n_acc++;
    if (r) begin
      check("free_in_rst", CW'(free_vld), CW'(0));
      q.delete();
      free_at.delete();
      done_at.delete();
      outstanding = 0;
      bidx        = 0;
      post_rst    = 1'b1;
    end else begin
      if (post_rst) begin
        check("rst_pld",      CW'(us_if.us_rsp_pld), CW'(0));
        check("rst_free_idx", CW'(free_idx), CW'(0));
        check("rst_done_idx", CW'(done_idx), CW'(0));
        check("rst_done",     CW'(done), CW'(0));
        post_rst = 1'b0;
      end
      exp_vld = (q.size() > 0) && (q[0].cap < cyc);
      check("rsp_vld", CW'(us_if.us_rsp_vld), CW'(exp_vld));
      if (exp_vld) begin
        line          = data_at[q[0].cap];
        eb.data       = line[bidx*BW +: BW];
        eb.txnid      = q[0].txn;
        eb.beat_idx   = RSP_BEAT_IDX_WIDTH'(bidx);
        eb.last       = (bidx == int'(BEATS) - 1);
        check("rsp_pld", CW'(us_if.us_rsp_pld), CW'(eb));
      end
      exp_free = free_at.exists(cyc);
      check("free_vld", CW'(free_vld), CW'(exp_free));
      if (exp_free) check("free_idx", CW'(free_idx), CW'(free_at[cyc]));
      exp_done = done_at.exists(cyc);
      check("rsp_done", CW'(done), CW'(exp_done));
      if (exp_done) check("done_idx", CW'(done_idx), CW'(done_at[cyc]));
      if (v && exp_rdy) begin
        outstanding++;
        free_at[cyc + int'(LAT)] = p.db_entry_id;
        q.push_back('{cap: cyc + int'(LAT), txn: p.txnid, rob: p.rob_entry_id});
      end
      if (exp_vld && ur) begin
        bidx++;
        if (bidx == int'(BEATS)) begin
          bidx = 0;
          done_at[cyc + 1] = q[0].rob;
          void'(q.pop_front());
          outstanding--;
        end
      end
    end
    cyc++;
  endtask

  task automatic idle(input int unsigned n, input logic ur);
    for (int unsigned i = 0; i < n; i++) cycle(1'b0, '0, ur, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    issue_vld = 1'b0;
    issue_pld = '0;
    rd_data = '0;
    us_if.us_rsp_rdy = 1'b0;

    for (int unsigned i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b1);
    idle(2, 1'b1);

    // Single launch with ready held high.
    cycle(1'b1, mk(3, 8'h11, 5), 1'b1, 1'b0);
    idle(10, 1'b1);

    // Launch every cycle while upstream stalls, then release.
    n_acc = 0;
    for (int unsigned i = 0; i < 8; i++) cycle(1'b1, mk(10 + i, 32 + i, i), 1'b0, 1'b0);
    check("flood_accepts", CW'(n_acc), CW'(4));
    idle(24, 1'b1);

    // Launch in the same cycle as a last-beat pop with one credit left.
    for (int unsigned i = 0; i < 3; i++) cycle(1'b1, mk(20 + i, 64 + i, 8 + i), 1'b0, 1'b0);
    idle(3, 1'b0);
    idle(3, 1'b1);
    cycle(1'b1, mk(30, 99, 12), 1'b1, 1'b0);
    idle(20, 1'b1);

    // Random traffic with random upstream backpressure.
    for (int unsigned i = 0; i < 400; i++)
      cycle(1'(($urandom_range(0, 1))),
            mk($urandom_range(0, 63), $urandom_range(0, 255), $urandom_range(0, 31)),
            ($urandom_range(0, 9) < 6), 1'b0);
    idle(30, 1'b1);

    // Reset with lines in flight, then a fresh launch.
    for (int unsigned i = 0; i < 3; i++) cycle(1'b1, mk(40 + i, 128 + i, 16 + i), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1);
    idle(10, 1'b1);
    cycle(1'b1, mk(7, 200, 9), 1'b1, 1'b0);
    idle(10, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
